// File: rtl/gpr_wb_arbiter.sv
// rtl/gpr_wb_arbiter.sv - register-file writeback arbiter with pending-write scoreboard
module gpr_wb_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_REGS   = 8,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_wb_valid,
  input  logic [ADDR_WIDTH-1:0] alu_wb_dest,
  input  logic [DATA_WIDTH-1:0] alu_wb_data,
  output logic                  alu_wb_ready,
  input  logic                  mem_wb_valid,
  input  logic [ADDR_WIDTH-1:0] mem_wb_dest,
  input  logic [DATA_WIDTH-1:0] mem_wb_data,
  output logic                  mem_wb_ready,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_dest,
  output logic                  issue_ready,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  write_en,
  output logic [ADDR_WIDTH-1:0] write_dest,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  wb_unexpected
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {PRI_ALU = 1'b0, PRI_MEM = 1'b1} pri_t;

  pri_t                  pri_q;
  logic                  alu_grant;
  logic                  mem_grant;
  logic                  wb_fire;
  logic                  issue_fire;
  logic                  unexpected_now;
  logic [NUM_REGS-1:0]   inc_vec;
  logic [NUM_REGS-1:0]   dec_vec;
  logic [CNT_WIDTH-1:0]  cnt [NUM_REGS];

  // Round-robin grant: a lone requester always wins, a tie goes to the pointer.
  always_comb begin
    alu_grant = alu_wb_valid && (!mem_wb_valid || (pri_q == PRI_ALU));
    mem_grant = mem_wb_valid && (!alu_wb_valid || (pri_q == PRI_MEM));
    wb_fire   = alu_grant || mem_grant;
  end

  assign alu_wb_ready = alu_grant;
  assign mem_wb_ready = mem_grant;

  // Priority pointer flips to the other requester after every accepted writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pri_q <= PRI_ALU;
    end else if (wb_fire) begin
      pri_q <= (pri_q == PRI_ALU) ? PRI_MEM : PRI_ALU;
    end
  end

  // Register the granted writeback so the register file sees it one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_en   <= 1'b0;
      write_dest <= '0;
      write_data <= '0;
    end else begin
      write_en <= wb_fire;
      if (wb_fire) begin
        write_dest <= alu_grant ? alu_wb_dest : mem_wb_dest;
        write_data <= alu_grant ? alu_wb_data : mem_wb_data;
      end
    end
  end

  // Issue is refused only when the destination counter is already saturated.
  always_comb begin
    issue_ready = (cnt[issue_dest] != CNT_MAX);
    issue_fire  = issue_valid && issue_ready;
  end

  // Per-register increment/decrement requests and detection of a commit nobody issued.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      inc_vec[i] = issue_fire && (issue_dest == ADDR_WIDTH'(i));
      dec_vec[i] = write_en && (write_dest == ADDR_WIDTH'(i));
    end
    unexpected_now = write_en && (cnt[write_dest] == '0) && !inc_vec[write_dest];
  end

  // Pending counters: issue and commit to the same register cancel; decrement floors at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (inc_vec[i] && !dec_vec[i]) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else if (dec_vec[i] && !inc_vec[i] && (cnt[i] != '0)) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  // Sticky flag for a commit that had no matching issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_unexpected <= 1'b0;
    end else if (unexpected_now) begin
      wb_unexpected <= 1'b1;
    end
  end

  // A register is busy while any write to it is still in flight.
  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy[i] = (cnt[i] != '0);
    end
  end

endmodule
